// File: rtl/alu_pipe_core.sv
// Two-operand ALU with split operand capture, partner timeout and a 2-stage multiply path.
// Results and flags are registered and announced by a one-cycle OUT_VALID strobe.
module alu_pipe_core #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 16,
    parameter int CW      = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic [1:0]      IN_VALID,
    output logic            IN_READY,
    input  logic [DW-1:0]   OPA,
    input  logic [DW-1:0]   OPB,
    input  logic            CIN,
    input  logic            MODE,
    input  logic [CW-1:0]   CMD,
    output logic            OUT_VALID,
    output logic [2*DW-1:0] RES,
    output logic            COUT,
    output logic            OFLOW,
    output logic            G,
    output logic            E,
    output logic            L,
    output logic            ERR
);
    localparam int         LW     = $clog2(DW);
    localparam logic [DW:0] ONE_W = (DW+1)'(1);
    localparam logic [7:0] CNT_TO = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_A, S_WAIT_B, S_EXEC, S_MUL, S_ERR} state_t;

    state_t          state_r, state_s;
    logic [7:0]      cnt_r, cnt_s;
    logic [DW-1:0]   a_r, a_s, b_r, b_s;
    logic [CW-1:0]   cmd_r, cmd_s;
    logic            mode_r, mode_s, cin_r, cin_s;
    logic [DW:0]     m1_r, m2_r, m1_s, m2_s;
    logic [2*DW-1:0] prod_s;
    logic [DW-1:0]   alu_res_s;
    logic            alu_cout_s, alu_oflow_s, alu_g_s, alu_e_s, alu_l_s, alu_err_s, is_mul_s;
    logic [DW:0]     wide_s;
    logic [2*DW-1:0] rot_s;

    // Operand acceptance is only possible while waiting for operands and not in reset.
    always_comb begin
        IN_READY = 1'b0;
        if (CE && !RST && (state_r == S_IDLE || state_r == S_WAIT_A || state_r == S_WAIT_B)) begin
            IN_READY = 1'b1;
        end else begin
            IN_READY = 1'b0;
        end
    end

    // Next-state and operand capture logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        a_s     = a_r;
        b_s     = b_r;
        cmd_s   = cmd_r;
        mode_s  = mode_r;
        cin_s   = cin_r;
        case (state_r)
            S_IDLE: begin
                case (IN_VALID)
                    2'b11: begin
                        a_s = OPA; b_s = OPB; cmd_s = CMD; mode_s = MODE; cin_s = CIN;
                        state_s = S_EXEC;
                    end
                    2'b01: begin
                        a_s = OPA; cmd_s = CMD; mode_s = MODE; cin_s = CIN;
                        cnt_s = 8'd0; state_s = S_WAIT_B;
                    end
                    2'b10: begin
                        b_s = OPB; cmd_s = CMD; mode_s = MODE; cin_s = CIN;
                        cnt_s = 8'd0; state_s = S_WAIT_A;
                    end
                    default: state_s = S_IDLE;
                endcase
            end
            S_WAIT_B: begin
                if (IN_VALID[1]) begin
                    b_s = OPB; state_s = S_EXEC;
                end else if (IN_VALID[0]) begin
                    a_s = OPA; cmd_s = CMD; mode_s = MODE; cin_s = CIN; cnt_s = 8'd0;
                end else if (cnt_r + 8'd1 == CNT_TO) begin
                    cnt_s = 8'd0; state_s = S_ERR;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            S_WAIT_A: begin
                if (IN_VALID[0]) begin
                    a_s = OPA; state_s = S_EXEC;
                end else if (IN_VALID[1]) begin
                    b_s = OPB; cmd_s = CMD; mode_s = MODE; cin_s = CIN; cnt_s = 8'd0;
                end else if (cnt_r + 8'd1 == CNT_TO) begin
                    cnt_s = 8'd0; state_s = S_ERR;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            S_EXEC:  state_s = is_mul_s ? S_MUL : S_IDLE;
            S_MUL:   state_s = S_IDLE;
            S_ERR:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Single-cycle datapath plus multiply stage-1 operand preparation.
    always_comb begin
        alu_res_s = '0; alu_cout_s = 1'b0; alu_oflow_s = 1'b0;
        alu_g_s = 1'b0; alu_e_s = 1'b0; alu_l_s = 1'b0; alu_err_s = 1'b0;
        is_mul_s = 1'b0; m1_s = '0; m2_s = '0; wide_s = '0; rot_s = '0;
        if (mode_r) begin
            case (cmd_r)
                CW'(0):  begin wide_s = {1'b0, a_r} + {1'b0, b_r}; alu_res_s = wide_s[DW-1:0]; alu_cout_s = wide_s[DW]; end
                CW'(1):  begin wide_s = {1'b0, a_r} - {1'b0, b_r}; alu_res_s = wide_s[DW-1:0]; alu_oflow_s = wide_s[DW]; end
                CW'(2):  begin wide_s = {1'b0, a_r} + {1'b0, b_r} + {{DW{1'b0}}, cin_r}; alu_res_s = wide_s[DW-1:0]; alu_cout_s = wide_s[DW]; end
                CW'(3):  begin wide_s = {1'b0, a_r} - {1'b0, b_r} - {{DW{1'b0}}, cin_r}; alu_res_s = wide_s[DW-1:0]; alu_oflow_s = wide_s[DW]; end
                CW'(4):  begin wide_s = {1'b0, a_r} + ONE_W; alu_res_s = wide_s[DW-1:0]; alu_cout_s = wide_s[DW]; end
                CW'(5):  begin wide_s = {1'b0, a_r} - ONE_W; alu_res_s = wide_s[DW-1:0]; alu_oflow_s = wide_s[DW]; end
                CW'(6):  begin wide_s = {1'b0, b_r} + ONE_W; alu_res_s = wide_s[DW-1:0]; alu_cout_s = wide_s[DW]; end
                CW'(7):  begin wide_s = {1'b0, b_r} - ONE_W; alu_res_s = wide_s[DW-1:0]; alu_oflow_s = wide_s[DW]; end
                CW'(8):  begin alu_g_s = (a_r > b_r); alu_e_s = (a_r == b_r); alu_l_s = (a_r < b_r); end
                CW'(9):  begin is_mul_s = 1'b1; m1_s = {1'b0, a_r} + ONE_W; m2_s = {1'b0, b_r} + ONE_W; end
                CW'(10): begin is_mul_s = 1'b1; m1_s = {1'b0, a_r[DW-2:0], 1'b0}; m2_s = {1'b0, b_r}; end
                default: alu_err_s = 1'b1;
            endcase
        end else begin
            case (cmd_r)
                CW'(0):  alu_res_s = a_r & b_r;
                CW'(1):  alu_res_s = ~(a_r & b_r);
                CW'(2):  alu_res_s = a_r | b_r;
                CW'(3):  alu_res_s = ~(a_r | b_r);
                CW'(4):  alu_res_s = a_r ^ b_r;
                CW'(5):  alu_res_s = ~(a_r ^ b_r);
                CW'(6):  alu_res_s = ~a_r;
                CW'(7):  alu_res_s = ~b_r;
                CW'(8):  alu_res_s = {1'b0, a_r[DW-1:1]};
                CW'(9):  alu_res_s = {a_r[DW-2:0], 1'b0};
                CW'(10): alu_res_s = {1'b0, b_r[DW-1:1]};
                CW'(11): alu_res_s = {b_r[DW-2:0], 1'b0};
                CW'(12): begin rot_s = {a_r, a_r} << b_r[LW-1:0]; alu_res_s = rot_s[2*DW-1:DW]; alu_err_s = |b_r[DW-1:LW]; end
                CW'(13): begin rot_s = {a_r, a_r} >> b_r[LW-1:0]; alu_res_s = rot_s[DW-1:0]; alu_err_s = |b_r[DW-1:LW]; end
                default: alu_err_s = 1'b1;
            endcase
        end
    end

    // Operands are widened to 2*DW so the truncation to the result width is the natural wrap.
    assign prod_s = {{(DW-1){1'b0}}, m1_r} * {{(DW-1){1'b0}}, m2_r};

    // Control state and captured operand registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= S_IDLE; cnt_r <= 8'd0;
            a_r <= '0; b_r <= '0; cmd_r <= '0; mode_r <= 1'b0; cin_r <= 1'b0;
        end else if (CE) begin
            state_r <= state_s; cnt_r <= cnt_s;
            a_r <= a_s; b_r <= b_s; cmd_r <= cmd_s; mode_r <= mode_s; cin_r <= cin_s;
        end
    end

    // Result registers: RES and flags change only together with an OUT_VALID strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0; RES <= '0; COUT <= 1'b0; OFLOW <= 1'b0;
            G <= 1'b0; E <= 1'b0; L <= 1'b0; ERR <= 1'b0; m1_r <= '0; m2_r <= '0;
        end else if (CE) begin
            OUT_VALID <= 1'b0;
            case (state_r)
                S_EXEC: begin
                    if (is_mul_s) begin
                        m1_r <= m1_s; m2_r <= m2_s;
                    end else begin
                        OUT_VALID <= 1'b1; RES <= {{DW{1'b0}}, alu_res_s};
                        COUT <= alu_cout_s; OFLOW <= alu_oflow_s;
                        G <= alu_g_s; E <= alu_e_s; L <= alu_l_s; ERR <= alu_err_s;
                    end
                end
                S_MUL: begin
                    OUT_VALID <= 1'b1; RES <= prod_s; COUT <= 1'b0; OFLOW <= 1'b0;
                    G <= 1'b0; E <= 1'b0; L <= 1'b0; ERR <= 1'b0;
                end
                S_ERR: begin
                    OUT_VALID <= 1'b1; RES <= '0; COUT <= 1'b0; OFLOW <= 1'b0;
                    G <= 1'b0; E <= 1'b0; L <= 1'b0; ERR <= 1'b1;
                end
                default: OUT_VALID <= 1'b0;
            endcase
        end
    end
endmodule
